// File: rtl/hex_msg_scroller_pkg.sv
// Mode codes, glyph bytes and the banner text table shared by the HEX scroller and its ROM.
// Glyphs are active-low segment bytes with bit 7 (decimal point) held at 1.
package hex_msg_scroller_pkg;

    localparam logic [3:0] MODE_IDLE   = 4'h0;
    localparam logic [3:0] MODE_HAZARD = 4'h1;
    localparam logic [3:0] MODE_RIGHT  = 4'h2;
    localparam logic [3:0] MODE_LEFT   = 4'h3;

    localparam int LEN_W     = 5;
    localparam int ROM_DEPTH = 16;

    typedef logic [7:0] glyph_t;

    localparam glyph_t G_A     = 8'h88;
    localparam glyph_t G_E     = 8'h86;
    localparam glyph_t G_F     = 8'h8E;
    localparam glyph_t G_LC_D  = 8'hA1;
    localparam glyph_t G_G     = 8'h90;
    localparam glyph_t G_H     = 8'h89;
    localparam glyph_t G_LC_H  = 8'h8B;
    localparam glyph_t G_I     = 8'hCF;
    localparam glyph_t G_LC_I  = 8'hEF;
    localparam glyph_t G_L     = 8'hC7;
    localparam glyph_t G_LC_T  = 8'h87;
    localparam glyph_t G_LC_R  = 8'hAF;
    localparam glyph_t G_Z     = 8'hA4;
    localparam glyph_t G_O     = 8'hC0;
    localparam glyph_t G_LC_N  = 8'hAB;
    localparam glyph_t G_BLANK = 8'hFF;

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic             blink;
    } msg_info_t;

    // Character 0 (leftmost letter of the text) sits in the low byte.
    localparam logic [8*ROM_DEPTH-1:0] MSG_IDLE =
        {{12{G_BLANK}}, G_E, G_L, G_LC_D, G_I};
    localparam logic [8*ROM_DEPTH-1:0] MSG_LEFT =
        {{12{G_BLANK}}, G_LC_T, G_F, G_E, G_L};
    localparam logic [8*ROM_DEPTH-1:0] MSG_RIGHT =
        {{11{G_BLANK}}, G_LC_T, G_LC_H, G_G, G_LC_I, G_LC_R};
    localparam logic [8*ROM_DEPTH-1:0] MSG_HAZARD =
        {{7{G_BLANK}}, G_LC_N, G_O, G_BLANK, G_LC_D, G_LC_R, G_A, G_Z, G_A, G_H};

    function automatic msg_info_t msg_info(input logic [3:0] mode);
        case (mode)
            MODE_IDLE:   return '{len: LEN_W'(4), blink: 1'b0};
            MODE_LEFT:   return '{len: LEN_W'(4), blink: 1'b0};
            MODE_RIGHT:  return '{len: LEN_W'(5), blink: 1'b0};
            MODE_HAZARD: return '{len: LEN_W'(9), blink: 1'b1};
            default:     return '{len: '0, blink: 1'b0};
        endcase
    endfunction

    function automatic glyph_t msg_glyph(input logic [3:0] mode, input logic [3:0] idx);
        logic [8*ROM_DEPTH-1:0] msg;
        case (mode)
            MODE_IDLE:   msg = MSG_IDLE;
            MODE_LEFT:   msg = MSG_LEFT;
            MODE_RIGHT:  msg = MSG_RIGHT;
            MODE_HAZARD: msg = MSG_HAZARD;
            default:     msg = '1;
        endcase
        return msg[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/hex_msg_rom.sv
// Combinational banner ROM: one glyph per digit index, plus length and blink flag of the mode.
// Any index at or beyond the message length reads as blank.
module hex_msg_rom
    import hex_msg_scroller_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int IDX_W      = 5
) (
    input  logic [3:0]                  mode_i,
    input  logic [NUM_DIGITS*IDX_W-1:0] idx_i,
    output logic [NUM_DIGITS*8-1:0]     glyph_o,
    output logic [LEN_W-1:0]            len_o,
    output logic                        blink_o
);

    msg_info_t info;

    assign info    = msg_info(mode_i);
    assign len_o   = info.len;
    assign blink_o = info.blink;

    always_comb begin
        glyph_o = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (int'(idx_i[k*IDX_W +: IDX_W]) < int'(info.len)) begin
                glyph_o[k*8 +: 8] = msg_glyph(mode_i, 4'(idx_i[k*IDX_W +: IDX_W]));
            end
        end
    end

endmodule

// File: rtl/hex_msg_scroller.sv
// HEX banner driver: shows the text for the current tail-light mode on NUM_DIGITS digits,
// scrolling long messages through a blank gap and blinking flagged modes.
module hex_msg_scroller
    import hex_msg_scroller_pkg::*;
#(
    parameter int NUM_DIGITS  = 6,
    parameter int MSG_LEN_MAX = 16,
    parameter int TICK_DIV    = 25_000_000,
    parameter int BLINK_DIV   = 12_500_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              csl,
    output logic [8*NUM_DIGITS-1:0] hex_out,
    output logic                    scrolling,
    output logic                    wrap
);

    localparam int OFS_W   = $clog2(MSG_LEN_MAX + NUM_DIGITS);
    localparam int TICK_W  = $clog2(TICK_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);

    logic [3:0]                  csl_q;
    logic [OFS_W-1:0]            offset_q, offset_d;
    logic [TICK_W-1:0]           tick_cnt_q, tick_cnt_d;
    logic [BLINK_W-1:0]          blink_cnt_q, blink_cnt_d;
    logic                        phase_q, phase_d;
    logic [8*NUM_DIGITS-1:0]     hex_q, hex_d;
    logic                        scrolling_q;
    logic                        wrap_q, wrap_d;

    logic [LEN_W-1:0]            msg_len;
    logic                        msg_blink;
    logic [NUM_DIGITS*OFS_W-1:0] char_idx;
    logic [8*NUM_DIGITS-1:0]     glyphs;
    logic                        mode_chg, is_scroll, tick_end, blink_end, ofs_end;

    hex_msg_rom #(
        .NUM_DIGITS (NUM_DIGITS),
        .IDX_W      (OFS_W)
    ) u_rom (
        .mode_i  (csl_q),
        .idx_i   (char_idx),
        .glyph_o (glyphs),
        .len_o   (msg_len),
        .blink_o (msg_blink)
    );

    assign mode_chg  = (csl != csl_q);
    assign is_scroll = (int'(msg_len) > NUM_DIGITS);
    assign tick_end  = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    assign blink_end = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
    assign ofs_end   = (offset_q == OFS_W'(int'(msg_len) + NUM_DIGITS - 1));

    // offset < P and the digit term < P, so one conditional subtract is a full mod P.
    always_comb begin
        int ring;
        int pos;
        ring     = int'(msg_len) + NUM_DIGITS;
        pos      = 0;
        char_idx = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (is_scroll) begin
                pos = int'(offset_q) + NUM_DIGITS - 1 - k;
                if (pos >= ring) pos = pos - ring;
            end else begin
                pos = int'(msg_len) - 1 - k;
            end
            if (pos >= 0) char_idx[k*OFS_W +: OFS_W] = OFS_W'(pos);
        end
    end

    always_comb begin
        offset_d    = offset_q;
        tick_cnt_d  = tick_cnt_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        wrap_d      = 1'b0;
        if (mode_chg) begin
            offset_d    = '0;
            tick_cnt_d  = '0;
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else begin
            if (!is_scroll) begin
                offset_d   = '0;
                tick_cnt_d = '0;
            end else if (tick_end) begin
                tick_cnt_d = '0;
                if (ofs_end) begin
                    offset_d = '0;
                    wrap_d   = 1'b1;
                end else begin
                    offset_d = offset_q + OFS_W'(1);
                end
            end else begin
                tick_cnt_d = tick_cnt_q + TICK_W'(1);
            end

            if (!msg_blink) begin
                blink_cnt_d = '0;
                phase_d     = 1'b0;
            end else if (blink_end) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    // phase only ever leaves 0 for blinking modes, so it alone gates the dark half-period
    assign hex_d = phase_q ? '1 : glyphs;

    always_ff @(posedge clk) begin
        if (reset) begin
            csl_q       <= csl;
            offset_q    <= '0;
            tick_cnt_q  <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            hex_q       <= '1;
            scrolling_q <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            csl_q       <= csl;
            offset_q    <= offset_d;
            tick_cnt_q  <= tick_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            hex_q       <= hex_d;
            scrolling_q <= is_scroll;
            wrap_q      <= wrap_d;
        end
    end

    assign hex_out   = hex_q;
    assign scrolling = scrolling_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_hex_msg_scroller.sv
// Directed bench for hex_msg_scroller with short scroll/blink dividers (TICK_DIV=4, BLINK_DIV=3).
module tb_hex_msg_scroller;
    import hex_msg_scroller_pkg::*;

    localparam logic [47:0] ALL_FF    = {6{8'hFF}};
    localparam logic [47:0] IDLE_TXT  = {8'hFF, 8'hFF, 8'hCF, 8'hA1, 8'hC7, 8'h86};
    localparam logic [47:0] RIGHT_TXT = {8'hFF, 8'hAF, 8'hEF, 8'h90, 8'h8B, 8'h87};
    localparam logic [47:0] LEFT_TXT  = {8'hFF, 8'hFF, 8'hC7, 8'h86, 8'h8E, 8'h87};
    localparam logic [47:0] HAZ_OFS0  = {8'h89, 8'h88, 8'hA4, 8'h88, 8'hAF, 8'hA1};
    localparam logic [47:0] HAZ_OFS1  = {8'h88, 8'hA4, 8'h88, 8'hAF, 8'hA1, 8'hFF};
    localparam logic [47:0] HAZ_OFS2  = {8'hA4, 8'h88, 8'hAF, 8'hA1, 8'hFF, 8'hC0};
    localparam logic [47:0] HAZ_OFS8  = {8'hAB, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    localparam logic [47:0] HAZ_OFS12 = {8'hFF, 8'hFF, 8'hFF, 8'h89, 8'h88, 8'hA4};

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  csl;
    logic [47:0] hex_out;
    logic        scrolling;
    logic        wrap;

    int checks = 0;
    int errors = 0;

    hex_msg_scroller #(
        .NUM_DIGITS  (6),
        .MSG_LEN_MAX (16),
        .TICK_DIV    (4),
        .BLINK_DIV   (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .csl       (csl),
        .hex_out   (hex_out),
        .scrolling (scrolling),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        csl   = MODE_IDLE;
        step(2);
        checks++;
        if (hex_out !== ALL_FF) begin errors++; $display("FAIL reset_hex: got %h want %h", hex_out, ALL_FF); end
        checks++;
        if (scrolling !== 1'b0) begin errors++; $display("FAIL reset_scrolling: got %b want 0", scrolling); end
        checks++;
        if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b want 0", wrap); end
        reset = 1'b0;
        step(1);
        checks++;
        if (hex_out !== IDLE_TXT) begin errors++; $display("FAIL idle_first_text: got %h want %h", hex_out, IDLE_TXT); end
        checks++;
        if (scrolling !== 1'b0) begin errors++; $display("FAIL idle_scrolling: got %b want 0", scrolling); end
    endtask

    task automatic test_static_right();
        int bad;
        int wraps;
        bad   = 0;
        wraps = 0;
        csl = MODE_RIGHT;
        step(1);
        checks++;
        if (hex_out !== IDLE_TXT) begin errors++; $display("FAIL right_latency_edge1: got %h want %h", hex_out, IDLE_TXT); end
        step(1);
        checks++;
        if (hex_out !== RIGHT_TXT) begin errors++; $display("FAIL right_text: got %h want %h", hex_out, RIGHT_TXT); end
        checks++;
        if (scrolling !== 1'b0) begin errors++; $display("FAIL right_scrolling: got %b want 0", scrolling); end
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (hex_out !== RIGHT_TXT) bad++;
            if (wrap !== 1'b0) wraps++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL right_hold: %0d cycles moved, want 0", bad); end
        checks++;
        if (wraps != 0) begin errors++; $display("FAIL right_no_wrap: %0d wrap cycles, want 0", wraps); end
    endtask

    task automatic test_hazard_scroll();
        int wraps;
        int wrap_at;
        wraps   = 0;
        wrap_at = -1;
        csl = MODE_HAZARD;
        step(1);
        for (int n = 1; n <= 61; n++) begin
            step(1);
            if (n <= 60 && wrap === 1'b1) begin
                wraps++;
                wrap_at = n;
            end
            case (n)
                1: begin
                    checks++;
                    if (hex_out !== HAZ_OFS0) begin errors++; $display("FAIL haz_ofs0: got %h want %h", hex_out, HAZ_OFS0); end
                    checks++;
                    if (scrolling !== 1'b1) begin errors++; $display("FAIL haz_scrolling: got %b want 1", scrolling); end
                end
                7: begin
                    checks++;
                    if (hex_out !== HAZ_OFS1) begin errors++; $display("FAIL haz_ofs1: got %h want %h", hex_out, HAZ_OFS1); end
                end
                9: begin
                    checks++;
                    if (hex_out !== HAZ_OFS2) begin errors++; $display("FAIL haz_ofs2: got %h want %h", hex_out, HAZ_OFS2); end
                end
                33: begin
                    checks++;
                    if (hex_out !== HAZ_OFS8) begin errors++; $display("FAIL haz_ofs8_gap: got %h want %h", hex_out, HAZ_OFS8); end
                end
                49: begin
                    checks++;
                    if (hex_out !== HAZ_OFS12) begin errors++; $display("FAIL haz_ofs12_ring: got %h want %h", hex_out, HAZ_OFS12); end
                end
                61: begin
                    checks++;
                    if (hex_out !== HAZ_OFS0) begin errors++; $display("FAIL haz_after_wrap: got %h want %h", hex_out, HAZ_OFS0); end
                end
                default: ;
            endcase
        end
        checks++;
        if (wraps != 1) begin errors++; $display("FAIL haz_wrap_count: got %0d want 1", wraps); end
        checks++;
        if (wrap_at != 60) begin errors++; $display("FAIL haz_wrap_cycle: got %0d want 60", wrap_at); end
    endtask

    task automatic test_blink();
        logic [47:0] exp_tbl [12];
        exp_tbl = '{HAZ_OFS0, HAZ_OFS0, HAZ_OFS0, ALL_FF, ALL_FF, ALL_FF,
                    HAZ_OFS1, HAZ_OFS1, HAZ_OFS2, ALL_FF, ALL_FF, ALL_FF};
        csl = MODE_IDLE;
        step(1);
        csl = MODE_HAZARD;
        step(1);
        for (int n = 1; n <= 12; n++) begin
            step(1);
            checks++;
            if (hex_out !== exp_tbl[n-1]) begin
                errors++;
                $display("FAIL blink_cycle%0d: got %h want %h", n, hex_out, exp_tbl[n-1]);
            end
        end
    endtask

    task automatic test_change_on_tick_and_reset();
        csl = MODE_IDLE;
        step(1);
        csl = MODE_HAZARD;
        step(1);
        step(59);
        csl = MODE_LEFT;
        step(1);
        checks++;
        if (wrap !== 1'b0) begin errors++; $display("FAIL change_on_wrap_edge: wrap got %b want 0", wrap); end
        step(1);
        checks++;
        if (hex_out !== LEFT_TXT) begin errors++; $display("FAIL left_text: got %h want %h", hex_out, LEFT_TXT); end
        checks++;
        if (scrolling !== 1'b0 || wrap !== 1'b0) begin
            errors++; $display("FAIL left_flags: scrolling=%b wrap=%b want 0 0", scrolling, wrap);
        end
        csl = MODE_HAZARD;
        step(2);
        checks++;
        if (hex_out !== HAZ_OFS0) begin errors++; $display("FAIL haz_reload_ofs0: got %h want %h", hex_out, HAZ_OFS0); end
        step(4);
        reset = 1'b1;
        step(1);
        checks++;
        if (hex_out !== ALL_FF) begin errors++; $display("FAIL midscroll_reset_hex: got %h want %h", hex_out, ALL_FF); end
        checks++;
        if (scrolling !== 1'b0 || wrap !== 1'b0) begin
            errors++; $display("FAIL midscroll_reset_flags: scrolling=%b wrap=%b want 0 0", scrolling, wrap);
        end
        reset = 1'b0;
        step(1);
        checks++;
        if (hex_out !== HAZ_OFS0) begin errors++; $display("FAIL post_reset_ofs0: got %h want %h", hex_out, HAZ_OFS0); end
        step(6);
        checks++;
        if (hex_out !== HAZ_OFS1) begin errors++; $display("FAIL post_reset_ofs1: got %h want %h", hex_out, HAZ_OFS1); end
    endtask

    task automatic test_invalid_mode();
        int bad;
        bad = 0;
        csl = 4'hF;
        step(2);
        checks++;
        if (hex_out !== ALL_FF) begin errors++; $display("FAIL invalid_hex: got %h want %h", hex_out, ALL_FF); end
        checks++;
        if (scrolling !== 1'b0) begin errors++; $display("FAIL invalid_scrolling: got %b want 0", scrolling); end
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (wrap !== 1'b0 || hex_out !== ALL_FF) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL invalid_hold: %0d bad cycles, want 0", bad); end
    endtask

    initial begin
        reset = 1'b1;
        csl   = MODE_IDLE;
        test_reset();
        test_static_right();
        test_hazard_scroll();
        test_blink();
        test_change_on_tick_and_reset();
        test_invalid_mode();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
